// File: rtl/trace_pkg.sv
// trace_pkg: shared constants and FSM state type for the trace readback path
package trace_pkg;
  localparam logic [7:0] HDR_BYTE = 8'hFF;
  localparam logic [7:0] PAD_BYTE = 8'h00;
  localparam int DEF_BASE_ADDR = 1;
  localparam int DEF_LAST_ADDR = 1023;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
endpackage

// File: rtl/trace_word_fifo.sv
// trace_word_fifo: first-word-fall-through word FIFO with occupancy count
module trace_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_pop;
  assign valid_o = count_q != '0;
  assign do_pop = pop_i & valid_o;
  // Head is gated so an empty FIFO presents zeros rather than stale data.
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/trace_reader.sv
// trace_reader: reads trace bytes from the capture RAM and streams them as packed 16-bit words
module trace_reader
  import trace_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int LAST_ADDR = DEF_LAST_ADDR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic              wr_busy,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              hdr_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST_A = (ADDR_W+1)'(LAST_ADDR);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, raddr_q;
  logic [ADDR_W:0] lo_addr;
  logic [CW-1:0] rsv_q, rsv_d, count;
  logic lo_phase_q, lo_phase_d, busy_q, busy_d, hdr_err_q, hdr_err_d, last_acc_q, last_acc_d;
  logic hi_vld_q, lo_vld_q, pad_q, first_q, last_q;
  logic [7:0] hi_byte_q;
  logic issue_hi, lo_ph, lo_pad, lo_rd, word_last, push, pop;
  logic [WORD_W:0] head;
  assign lo_addr = {1'b0, ptr_q} + (ADDR_W+1)'(1);
  assign lo_pad = lo_addr > LAST_A;
  assign word_last = lo_addr >= LAST_A;
  // A hi read only starts a word when the FIFO is guaranteed room for it.
  assign issue_hi = state_q == ISSUE && !lo_phase_q && (count + rsv_q) < DEPTH_C;
  assign lo_ph = state_q == ISSUE && lo_phase_q;
  assign lo_rd = lo_ph && !lo_pad;
  assign mem_re = issue_hi | lo_rd;
  assign mem_raddr = issue_hi ? ptr_q : lo_rd ? lo_addr[ADDR_W-1:0] : raddr_q;
  assign push = lo_vld_q;
  assign pop = out_valid & out_ready;
  assign out_data = head[WORD_W-1:0];
  assign out_last = head[WORD_W];
  assign busy = busy_q;
  assign done = state_q == DONE;
  assign hdr_err = hdr_err_q;
  trace_word_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W + 1)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i ({last_q, hi_byte_q, pad_q ? PAD_BYTE : mem_rdata}),
    .pop_i  (pop),
    .data_o (head),
    .valid_o(out_valid),
    .count_o(count)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    lo_phase_d = lo_phase_q;
    busy_d = busy_q;
    hdr_err_d = (hi_vld_q && first_q && mem_rdata != HDR_BYTE) ? 1'b1 : hdr_err_q;
    last_acc_d = last_acc_q | (pop & out_last);
    rsv_d = rsv_q + CW'(issue_hi) - CW'(push);
    case (state_q)
      IDLE: if (rd_start && !wr_busy) begin
        state_d = ISSUE;
        busy_d = 1'b1;
        hdr_err_d = 1'b0;
        ptr_d = BASE_A;
        lo_phase_d = 1'b0;
        last_acc_d = 1'b0;
      end
      ISSUE: begin
        if (issue_hi) lo_phase_d = 1'b1;
        if (lo_ph) begin
          lo_phase_d = 1'b0;
          ptr_d = ptr_q + ADDR_W'(2);
          state_d = word_last ? DRAIN : ISSUE;
        end
      end
      DRAIN: state_d = (count == '0 && rsv_q == '0 && last_acc_q) ? DONE : DRAIN;
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= BASE_A;
      lo_phase_q <= 1'b0;
      rsv_q <= '0;
      busy_q <= 1'b0;
      hdr_err_q <= 1'b0;
      last_acc_q <= 1'b0;
      raddr_q <= '0;
      hi_vld_q <= 1'b0;
      lo_vld_q <= 1'b0;
      pad_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      hi_byte_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      lo_phase_q <= lo_phase_d;
      rsv_q <= rsv_d;
      busy_q <= busy_d;
      hdr_err_q <= hdr_err_d;
      last_acc_q <= last_acc_d;
      raddr_q <= mem_raddr;
      hi_vld_q <= issue_hi;
      lo_vld_q <= lo_ph;
      pad_q <= lo_pad;
      first_q <= issue_hi && ptr_q == BASE_A;
      last_q <= word_last;
      hi_byte_q <= hi_vld_q ? mem_rdata : hi_byte_q;
    end
  end
endmodule
